// File: rtl/r_cpu_pkg.sv
// Shared constants and types for the R-type CPU control path.
// Holds ALU operation codes, R-type funct codes and the sequencer state type.
package r_cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/r_cpu_decode.sv
// Combinational funct decoder: maps an R-type funct field to an ALU operation
// and flags funct codes the ALU does not implement.
module r_cpu_decode
  import r_cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic [2:0] alu_op
);

  always_comb begin
    legal  = 1'b1;
    alu_op = ALU_AND;
    case (funct)
      FUNCT_ADD: alu_op = ALU_ADD;
      FUNCT_SUB: alu_op = ALU_SUB;
      FUNCT_AND: alu_op = ALU_AND;
      FUNCT_OR:  alu_op = ALU_OR;
      FUNCT_XOR: alu_op = ALU_XOR;
      FUNCT_NOR: alu_op = ALU_NOR;
      FUNCT_SLT: alu_op = ALU_SLT;
      FUNCT_SLL: alu_op = ALU_SLL;
      default: begin
        legal  = 1'b0;
        alu_op = ALU_AND;
      end
    endcase
  end

endmodule

// File: rtl/r_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type CPU: owns the IR,
// the retired-instruction counter, and the fetch/writeback strobes.
module r_cpu_sequencer
  import r_cpu_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [31:0]        Inst_code,
  output logic               IR_Write,
  output logic               PC_Write,
  output logic               Reg_Write,
  output logic [2:0]         ALU_OP,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] inst_count
);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [31:0]        ir_q;
  logic [2:0]         alu_op_q;
  logic [COUNT_W-1:0] count_q;

  logic               dec_legal;
  logic [2:0]         dec_alu_op;
  logic               inst_legal;

  r_cpu_decode u_decode (
    .funct  (ir_q[5:0]),
    .legal  (dec_legal),
    .alu_op (dec_alu_op)
  );

  assign inst_legal = dec_legal && (ir_q[31:26] == OPCODE_RTYPE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      alu_op_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        ir_q <= Inst_code;
      end
      if (state_q == S_DECODE && inst_legal) begin
        alu_op_q <= dec_alu_op;
      end
      if (state_q == S_WB) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = inst_legal ? S_EXEC : S_HALT;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes come straight from the registered state and IR, so they cannot glitch.
  // ALU_OP shows the live decode during DECODE and the registered copy afterwards.
  always_comb begin
    IR_Write  = (state_q == S_FETCH);
    PC_Write  = (state_q == S_WB);
    Reg_Write = (state_q == S_WB) && (ir_q[15:11] != '0);
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = (state_q == S_HALT);
    ALU_OP    = (state_q == S_DECODE) ? dec_alu_op : alu_op_q;
  end

  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign shamt      = ir_q[10:6];
  assign inst_count = count_q;

endmodule

// File: tb/tb_r_cpu_sequencer.sv
// Scoreboard bench for r_cpu_sequencer: directed programs push expected
// retirements/halts, a monitor pops and compares on each PC_Write or halt.
module tb_r_cpu_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          step;
  logic [31:0]   Inst_code;
  logic          IR_Write;
  logic          PC_Write;
  logic          Reg_Write;
  logic [2:0]    ALU_OP;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic          busy;
  logic          halted;
  logic [CW-1:0] inst_count;

  r_cpu_sequencer #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .Inst_code  (Inst_code),
    .IR_Write   (IR_Write),
    .PC_Write   (PC_Write),
    .Reg_Write  (Reg_Write),
    .ALU_OP     (ALU_OP),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .busy       (busy),
    .halted     (halted),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // Fetch-stage model: ROM indexed by PC, PC advances by 4 on PC_Write.
  logic [31:0] rom [16];
  logic [31:0] pc;
  assign Inst_code = rom[pc[5:2]];

  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else if (PC_Write) pc <= pc + 32'd4;
  end

  typedef struct {
    logic          is_halt;
    logic [4:0]    rs, rt, rd, sh;
    logic [2:0]    alu;
    logic          regw;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  rs, rt, rd, sh;
    logic [2:0]  alu;
    logic        regw;
  } vec_t;

  exp_t          sb[$];
  vec_t          prog_b [16];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt;
  logic          prev_halted = 1'b0;

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, h, input logic [5:0] f);
    return {6'b000000, s, t, d, h, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic [4:0] s, t, d, h, input logic [5:0] f,
                      input logic [2:0] alu, input logic regw);
    prog_b[i].word = rtype(s, t, d, h, f);
    prog_b[i].rs = s; prog_b[i].rt = t; prog_b[i].rd = d; prog_b[i].sh = h;
    prog_b[i].alu = alu; prog_b[i].regw = regw;
  endtask

  task automatic push_exp(input logic [4:0] s, t, d, h, input logic [2:0] alu, input logic regw);
    exp_t e;
    e.is_halt = 1'b0; e.rs = s; e.rt = t; e.rd = d; e.sh = h;
    e.alu = alu; e.regw = regw; e.cnt = exp_cnt;
    exp_cnt = exp_cnt + 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_vec(input int i);
    push_exp(prog_b[i].rs, prog_b[i].rt, prog_b[i].rd, prog_b[i].sh, prog_b[i].alu, prog_b[i].regw);
  endtask

  task automatic push_halt();
    exp_t e;
    e = '{is_halt: 1'b1, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0, alu: 3'd0, regw: 1'b0, cnt: exp_cnt};
    sb.push_back(e);
  endtask

  // Monitor: consumes one expectation per retirement (PC_Write) or halt entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (PC_Write) begin
        if (sb.size() == 0 || sb[0].is_halt) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire: got PC_Write=1 rd=%0d expected no retirement at %0t", rd, $time);
        end else begin
          e = sb.pop_front();
          check("retire", {rs, rt, rd, shamt, ALU_OP, Reg_Write, inst_count},
                {e.rs, e.rt, e.rd, e.sh, e.alu, e.regw, e.cnt});
        end
      end
      if (halted && !prev_halted) begin
        if (sb.size() == 0 || !sb[0].is_halt) begin
          checks++;
          failures++;
          $display("FAIL unexpected_halt: got halted=1 expected running at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("halt_entry", {inst_count, Reg_Write, PC_Write, IR_Write, busy},
                {e.cnt, 1'b0, 1'b0, 1'b0, 1'b0});
        end
      end
      prev_halted = halted;
    end
  end

  initial begin
    reset = 1'b0;
    run = 1'b0;
    step = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) rom[i] = 32'd0;

    setv(0,  5'd6,  5'd7,  5'd8,  5'd0, 6'h24, 3'b000, 1'b1);
    setv(1,  5'd9,  5'd10, 5'd11, 5'd0, 6'h25, 3'b001, 1'b1);
    setv(2,  5'd12, 5'd13, 5'd14, 5'd0, 6'h26, 3'b010, 1'b1);
    setv(3,  5'd15, 5'd16, 5'd17, 5'd0, 6'h27, 3'b011, 1'b1);
    setv(4,  5'd18, 5'd19, 5'd20, 5'd0, 6'h2a, 3'b110, 1'b1);
    setv(5,  5'd0,  5'd21, 5'd22, 5'd5, 6'h00, 3'b111, 1'b1);
    setv(6,  5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 3'b100, 1'b1);
    setv(7,  5'd3,  5'd1,  5'd0,  5'd0, 6'h22, 3'b101, 1'b0);
    setv(8,  5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 3'b111, 1'b0);
    setv(9,  5'd31, 5'd30, 5'd29, 5'd0, 6'h20, 3'b100, 1'b1);
    setv(10, 5'd28, 5'd27, 5'd26, 5'd0, 6'h22, 3'b101, 1'b1);
    setv(11, 5'd25, 5'd24, 5'd23, 5'd7, 6'h24, 3'b000, 1'b1);
    setv(12, 5'd1,  5'd1,  5'd1,  5'd0, 6'h25, 3'b001, 1'b1);
    setv(13, 5'd2,  5'd2,  5'd0,  5'd0, 6'h26, 3'b010, 1'b0);
    setv(14, 5'd3,  5'd3,  5'd3,  5'd0, 6'h27, 3'b011, 1'b1);
    setv(15, 5'd4,  5'd5,  5'd6,  5'd0, 6'h2a, 3'b110, 1'b1);

    // Free-run into an illegal load word at PC 8.
    rom[0] = 32'h00221820;
    rom[1] = rtype(5'd4, 5'd5, 5'd0, 5'd0, 6'h22);
    rom[2] = 32'h8C220004;
    tick();
    tick();
    check("reset_state", {IR_Write, PC_Write, Reg_Write, busy, halted, ALU_OP, rs, rt, rd, shamt, inst_count}, '0);
    reset = 1'b1;
    tick();
    check("idle_no_run", {busy, IR_Write, PC_Write}, 3'b000);

    push_exp(5'd1, 5'd2, 5'd3, 5'd0, 3'b100, 1'b1);
    push_exp(5'd4, 5'd5, 5'd0, 5'd0, 3'b101, 1'b0);
    push_halt();
    run = 1'b1;
    tick();
    check("fetch_cycle1", {IR_Write, busy, PC_Write, rd}, {1'b1, 1'b1, 1'b0, 5'd0});
    tick();
    check("decode_alu_op", {rd, ALU_OP, IR_Write}, {5'd3, 3'b100, 1'b0});
    for (int i = 0; i < 40 && !halted; i++) tick();
    check("halt_reached", halted, 1'b1);
    check("halt_pc_held", pc, 32'd8);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("halt_sticky", {halted, busy, IR_Write, PC_Write, inst_count}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd2});
    run = 1'b0;

    // Single step, with a second step pulse landing in EXEC.
    reset = 1'b0;
    tick();
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) rom[i] = prog_b[i].word;
    tick();
    reset = 1'b1;
    tick();
    push_vec(0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch", {IR_Write, busy}, 2'b11);
    tick();
    tick();
    check("step_exec", {IR_Write, PC_Write, busy}, 3'b001);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("step_idle", {busy, IR_Write, PC_Write, inst_count}, {1'b0, 1'b0, 1'b0, 4'd1});
    tick();
    check("step_ignored", {busy, IR_Write}, 2'b00);

    // Free-run five instructions, dropping run while the fifth is in DECODE.
    for (int i = 1; i <= 5; i++) push_vec(i);
    run = 1'b1;
    repeat (18) tick();
    check("decode_sll", {ALU_OP, rd, IR_Write}, {3'b111, 5'd22, 1'b0});
    run = 1'b0;
    tick();
    tick();
    tick();
    check("run_drop_idle", {busy, inst_count, PC_Write}, {1'b0, 4'd6, 1'b0});
    tick();
    tick();
    check("stays_idle", {busy, IR_Write}, 2'b00);

    // Reset asserted during EXEC aborts the instruction.
    run = 1'b1;
    tick();
    tick();
    tick();
    check("exec_state", {busy, PC_Write}, 2'b10);
    reset = 1'b0;
    #1;
    check("reset_abort", {IR_Write, PC_Write, Reg_Write, busy, halted, ALU_OP, rs, rt, rd, shamt, inst_count}, '0);
    check("reset_pc", pc, 32'd0);
    tick();
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) push_vec(i);
    push_vec(0);
    reset = 1'b1;
    tick();
    check("restart_fetch", {IR_Write, busy, inst_count}, {1'b1, 1'b1, 4'd0});
    repeat (64) tick();
    check("wrap_zero", {inst_count, IR_Write}, {4'd0, 1'b1});
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    check("wrap_then_idle", {busy, inst_count, halted}, {1'b0, 4'd1, 1'b0});

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_cpu_sequencer.md
# r_cpu_sequencer

Multi-cycle control sequencer for the R-type CPU. It gates the fetch datapath's PC advance and instruction-register load, and decodes the latched R-type instruction into register-file addresses, ALU operation and write enable. Sits between the fetch stage (PC/instruction ROM) and the register file/ALU. Supports free-run and single-step execution, and halts on an illegal instruction.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- run  in  1  level; instructions execute back-to-back while 1
- step  in  1  one-cycle pulse; executes exactly one instruction when run=0 and state is IDLE
- Inst_code  in  32  instruction word from ROM at current PC (combinational, valid in FETCH)
- IR_Write  out  1  high in FETCH; the internal IR captures Inst_code on that rising edge
- PC_Write  out  1  one-cycle pulse in WB; fetch stage advances PC by 4
- Reg_Write  out  1  register-file write enable, WB only, suppressed when rd=0
- ALU_OP  out  3  ALU operation, valid from DECODE through WB
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11] from the latched IR
- shamt  out  5  IR[10:6]
- busy  out  1  1 in any state other than IDLE and HALT
- halted  out  1  1 in HALT
- inst_count  out  COUNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Encoding is local to the block.
- IDLE: go to FETCH if run=1 or step=1, otherwise stay.
- FETCH: IR_Write=1, IR<=Inst_code. Always go to DECODE.
- DECODE: legal means IR[31:26]=0 and funct is one of ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLL 000000. Illegal goes to HALT; legal goes to EXEC and registers ALU_OP.
- ALU_OP map: AND 000, OR 001, XOR 010, NOR 011, ADD 100, SUB 101, SLT 110, SLL 111.
- EXEC: no strobes; ALU settles. Always go to WB.
- WB: PC_Write=1, Reg_Write=(rd!=0), inst_count+=1 with wrap at 2^COUNT_W. Next state is FETCH if run=1, otherwise IDLE.
- HALT: all strobes 0, halted=1. Only reset exits HALT. An illegal instruction does not pulse PC_Write, so PC stays on the offending word.
- step is ignored while run=1 or while the state is not IDLE.
- run falling mid-instruction: the current instruction completes, then the block goes to IDLE.

## Timing
- Reset values: state IDLE; IR=0; IR_Write, PC_Write, Reg_Write, busy, halted = 0; ALU_OP=000; rs, rt, rd, shamt = 0; inst_count=0.
- Reset asserted mid-instruction aborts the instruction; no PC_Write or Reg_Write is issued.
- Strobes are Moore outputs decoded from the registered state, glitch-free, and last exactly one cycle per instruction.
- Free-run: 4 cycles per instruction, in the order FETCH, DECODE, EXEC, WB.
- Step: the step pulse at edge N leads to FETCH in cycle N+1 and WB in cycle N+4.
- rs, rt, rd and shamt change only on the edge that ends FETCH.

## Structure
- Shared package r_cpu_pkg holds:
  - ALU_OP constants (ALU_AND to ALU_SLL)
  - funct constants (FUNCT_ADD etc.)
  - OPCODE_RTYPE = 6'b000000
- Sub-module r_cpu_decode is a purely combinational function: funct in, {legal, ALU_OP} out.
- The sequencer holds the FSM, the IR and the counter.

## Test plan
- Free-run: reset low, then high; run=1; ROM[0]=0x00221820 (add $3,$1,$2) → IR_Write at cycle 1, PC_Write and Reg_Write at cycle 4, rd=3, ALU_OP=100, inst_count=1.
- Single step: run=0; one step pulse → exactly one PC_Write four cycles later, then IDLE with busy=0. A second step pulse during EXEC is ignored.
- Illegal instruction: opcode 0x23 at PC 8 → HALT after DECODE, halted=1, no PC_Write, inst_count unchanged. A step pulse in HALT has no effect.
- rd=0: SUB with rd=0 → Reg_Write stays 0, PC_Write still pulses.
- Reset during EXEC: reset low, then high → all outputs at reset values, no PC_Write during the abort, restart begins in FETCH.
- Wrap-around: COUNT_W=4, 16 instructions retired → inst_count reads 0. run dropped during DECODE → WB completes, then IDLE.
